// File: rtl/caf_pkg.sv
// Shared constants for the stream blocks: FSM state encodings and parameter limits.
package caf_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    localparam int CAF_MIN_LENGTH = 2;
    localparam int CAF_MAX_LENGTH = 4096;

endpackage

// File: rtl/cpx_accumulate_if.sv
// Stream bundle between the complex multiplier, the accumulator and the downstream sink.
interface cpx_accumulate_if #(
    parameter int i_bits     = 24,
    parameter int q_bits     = 24,
    parameter int sum_i_bits = 28,
    parameter int sum_q_bits = 28
);
    logic                         m_axis_tvalid;
    logic signed [i_bits-1:0]     xi;
    logic signed [q_bits-1:0]     xq;
    logic                         s_axis_tready;
    logic                         m_axis_tready;
    logic                         s_axis_tvalid;
    logic signed [sum_i_bits-1:0] i;
    logic signed [sum_q_bits-1:0] q;

    // master: the environment around the accumulator (sample source and sum sink)
    modport master (
        output m_axis_tvalid, xi, xq, m_axis_tready,
        input  s_axis_tready, s_axis_tvalid, i, q
    );

    modport slave (
        input  m_axis_tvalid, xi, xq, m_axis_tready,
        output s_axis_tready, s_axis_tvalid, i, q
    );
endinterface

// File: rtl/cpx_accumulate.sv
// Sums `length` complex samples into one wide complex result and holds it until
// the downstream side takes it; growth bits make the sum exact.
module cpx_accumulate
    import caf_pkg::*;
#(
    parameter int i_bits     = 24,
    parameter int q_bits     = 24,
    parameter int length     = 16,
    parameter int cnt_bits   = $clog2(length),
    parameter int sum_i_bits = i_bits + cnt_bits,
    parameter int sum_q_bits = q_bits + cnt_bits
) (
    input  logic              clk,
    input  logic              reset,
    cpx_accumulate_if.slave   bus
);

    acc_state_t state_reg, state_next;

    logic        [cnt_bits-1:0]   cnt_reg;
    logic signed [sum_i_bits-1:0] acc_i_reg, i_reg;
    logic signed [sum_q_bits-1:0] acc_q_reg, q_reg;

    logic                         accept;
    logic                         last;
    logic signed [sum_i_bits-1:0] xi_ext, sum_i;
    logic signed [sum_q_bits-1:0] xq_ext, sum_q;

    assign accept = bus.m_axis_tvalid && (state_reg == ACCUM);
    assign last   = (cnt_reg == cnt_bits'(length - 1));

    assign xi_ext = {{(sum_i_bits - i_bits){bus.xi[i_bits-1]}}, bus.xi};
    assign xq_ext = {{(sum_q_bits - q_bits){bus.xq[q_bits-1]}}, bus.xq};
    assign sum_i  = acc_i_reg + xi_ext;
    assign sum_q  = acc_q_reg + xq_ext;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (accept && last)       state_next = HOLD;
            HOLD:    if (bus.m_axis_tready)    state_next = ACCUM;
            default:                           state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ACCUM;
            cnt_reg   <= '0;
            acc_i_reg <= '0;
            acc_q_reg <= '0;
            i_reg     <= '0;
            q_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                if (last) begin
                    // The closing sample goes straight into the result, so the
                    // accumulators restart at zero for the next frame.
                    i_reg     <= sum_i;
                    q_reg     <= sum_q;
                    acc_i_reg <= '0;
                    acc_q_reg <= '0;
                    cnt_reg   <= '0;
                end else begin
                    acc_i_reg <= sum_i;
                    acc_q_reg <= sum_q;
                    cnt_reg   <= cnt_reg + cnt_bits'(1);
                end
            end
        end
    end

    assign bus.s_axis_tready = (state_reg == ACCUM);
    assign bus.s_axis_tvalid = (state_reg == HOLD);
    assign bus.i             = i_reg;
    assign bus.q             = q_reg;

endmodule

// File: tb/tb_cpx_accumulate.sv
// Directed and random checks of cpx_accumulate (length 4, 24-bit inputs) against
// a frame-level model: a queue of accepted samples and a pending-sum flag.
module tb_cpx_accumulate;

    localparam int L  = 4;
    localparam int IB = 24;
    localparam int QB = 24;
    localparam int SI = IB + $clog2(L);
    localparam int SQ = QB + $clog2(L);

    logic clk = 1'b0;
    logic reset;

    cpx_accumulate_if #(.i_bits(IB), .q_bits(QB), .sum_i_bits(SI), .sum_q_bits(SQ)) bus ();

    cpx_accumulate #(.i_bits(IB), .q_bits(QB), .length(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: samples accepted in the current frame, and the sum awaiting pickup.
    longint fq_i[$];
    longint fq_q[$];
    bit     pending = 1'b0;
    longint exp_i   = 0;
    longint exp_q   = 0;
    int     n_frames = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare outputs.
    task automatic cycle(input logic v, input logic signed [IB-1:0] a,
                         input logic signed [QB-1:0] b, input logic rdy, input logic rst);
        longint si, sq;
        bus.m_axis_tvalid = v;
        bus.xi            = a;
        bus.xq            = b;
        bus.m_axis_tready = rdy;
        reset             = rst;
        @(posedge clk);
        if (rst) begin
            pending = 1'b0;
            fq_i.delete();
            fq_q.delete();
            exp_i = 0;
            exp_q = 0;
        end else if (pending) begin
            if (rdy) pending = 1'b0;
        end else if (v) begin
            fq_i.push_back(longint'(a));
            fq_q.push_back(longint'(b));
            if (fq_i.size() == L) begin
                si = 0;
                sq = 0;
                foreach (fq_i[k]) si += fq_i[k];
                foreach (fq_q[k]) sq += fq_q[k];
                exp_i = si;
                exp_q = sq;
                pending = 1'b1;
                n_frames++;
                fq_i.delete();
                fq_q.delete();
            end
        end
        #1;
        check("s_axis_tready", bus.s_axis_tready, !pending);
        check("s_axis_tvalid", bus.s_axis_tvalid, pending);
        check("sum_i", bus.i, exp_i);
        check("sum_q", bus.q, exp_q);
        $display("t=%0t rst=%0b v=%0b x=(%0d,%0d) rdy=%0b -> tready=%0b tvalid=%0b sum=(%0d,%0d)",
                 $time, rst, v, a, b, rdy, bus.s_axis_tready, bus.s_axis_tvalid, bus.i, bus.q);
    endtask

    task automatic rand_xy(output logic signed [IB-1:0] a, output logic signed [QB-1:0] b);
        logic [31:0] r1, r2;
        r1 = $urandom;
        r2 = $urandom;
        a = r1[IB-1:0];
        b = r2[QB-1:0];
    endtask

    logic signed [IB-1:0] ra;
    logic signed [QB-1:0] rb;
    logic [6:0] vpat;

    initial begin
        bus.m_axis_tvalid = 1'b0;
        bus.xi = '0;
        bus.xq = '0;
        bus.m_axis_tready = 1'b0;
        reset = 1'b1;

        // Reset state
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        cycle(1'b1, 5, 5, 1'b1, 1'b1);
        check("reset_tready", bus.s_axis_tready, 1);
        check("reset_sum_i", bus.i, 0);

        // Reference frame, downstream stalled for 10 cycles with junk inputs
        cycle(1'b1,  1,  2, 1'b0, 1'b0);
        cycle(1'b1,  3, -4, 1'b0, 1'b0);
        cycle(1'b1,  5,  6, 1'b0, 1'b0);
        cycle(1'b1, -7,  8, 1'b0, 1'b0);
        check("frame_i", bus.i, 2);
        check("frame_q", bus.q, 12);
        check("frame_tvalid", bus.s_axis_tvalid, 1);
        for (int k = 0; k < 10; k++) begin
            rand_xy(ra, rb);
            cycle(1'b1, ra, rb, 1'b0, 1'b0);
        end
        check("stall_i", bus.i, 2);
        check("stall_q", bus.q, 12);
        check("stall_tready", bus.s_axis_tready, 0);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);
        check("release_tready", bus.s_axis_tready, 1);

        // Same frame with continuous ready
        cycle(1'b1,  1,  2, 1'b1, 1'b0);
        cycle(1'b1,  3, -4, 1'b1, 1'b0);
        cycle(1'b1,  5,  6, 1'b1, 1'b0);
        cycle(1'b1, -7,  8, 1'b1, 1'b0);
        check("frame2_i", bus.i, 2);
        check("frame2_tvalid", bus.s_axis_tvalid, 1);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Extreme values: sum must not wrap
        for (int k = 0; k < L; k++) cycle(1'b1, -24'sd8388608, 24'sd8388607, 1'b0, 1'b0);
        check("extreme_i", bus.i, -64'sd33554432);
        check("extreme_q", bus.q, 64'sd33554428);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Valid toggling 1,0,0,1,1,0,1 with junk on the idle cycles
        vpat = 7'b1011001;
        for (int k = 0; k < 7; k++) begin
            rand_xy(ra, rb);
            cycle(vpat[k], ra, rb, 1'b0, 1'b0);
        end
        check("gaps_tvalid", bus.s_axis_tvalid, 1);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Reset mid-frame (with a simultaneous valid sample), then a clean frame
        for (int k = 0; k < 2; k++) begin
            rand_xy(ra, rb);
            cycle(1'b1, ra, rb, 1'b1, 1'b0);
        end
        cycle(1'b1, 100, 100, 1'b1, 1'b1);
        cycle(1'b1, 10, 20, 1'b0, 1'b0);
        cycle(1'b1, 30, 40, 1'b0, 1'b0);
        cycle(1'b1, -50, 60, 1'b0, 1'b0);
        cycle(1'b1, 70, -80, 1'b0, 1'b0);
        check("post_reset_i", bus.i, 60);
        check("post_reset_q", bus.q, 40);

        // Reset while a sum is held
        cycle(1'b0, 0, 0, 1'b1, 1'b1);
        check("hold_reset_tvalid", bus.s_axis_tvalid, 0);
        check("hold_reset_i", bus.i, 0);
        check("hold_reset_q", bus.q, 0);

        // Back-to-back random frames with ready high: one hold cycle per frame
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < L; k++) begin
                rand_xy(ra, rb);
                cycle(1'b1, ra, rb, 1'b1, 1'b0);
            end
            check("b2b_hold", bus.s_axis_tvalid, 1);
            rand_xy(ra, rb);
            cycle(1'b1, ra, rb, 1'b1, 1'b0);
            check("b2b_resume", bus.s_axis_tready, 1);
        end
        cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            rand_xy(ra, rb);
            cycle($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 80) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cpx_accumulate.md
CPX_ACCUMULATE -- requirements
Module: cpx_accumulate

Interface
REQ-001 Parameter i_bits, default 24: width of the signed input real part.
REQ-002 Parameter q_bits, default 24: width of the signed input imaginary part.
REQ-003 Parameter length, default 16: number of samples per sum; any integer 2..4096.
REQ-004 Parameter cnt_bits, default $clog2(length): width of the sample counter and of the growth bits.
REQ-005 Parameter sum_i_bits, default i_bits+cnt_bits: output real width.
REQ-006 Parameter sum_q_bits, default q_bits+cnt_bits: output imaginary width.
REQ-007 Port clk, input, 1: sole clock; all logic on its rising edge.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Port m_axis_tvalid, input, 1: upstream sample valid; driven by the complex multiplier's s_axis_tvalid.
REQ-010 Port xi, input, i_bits signed: upstream sample real part.
REQ-011 Port xq, input, q_bits signed: upstream sample imaginary part.
REQ-012 Port s_axis_tready, output, 1: block accepts a sample this cycle; feeds the multiplier's m_axis_tready.
REQ-013 Port m_axis_tready, input, 1: downstream ready for the sum.
REQ-014 Port s_axis_tvalid, output, 1: sum valid.
REQ-015 Port i, output, sum_i_bits signed: accumulated real sum.
REQ-016 Port q, output, sum_q_bits signed: accumulated imaginary sum.

Function
REQ-017 A sample SHALL be accepted exactly on a rising edge where m_axis_tvalid and s_axis_tready are both 1.
REQ-018 The FSM SHALL have two states: ACCUM (s_axis_tready=1, s_axis_tvalid=0) and HOLD (s_axis_tready=0, s_axis_tvalid=1); both outputs decode from state only.
REQ-019 In ACCUM, each accepted sample SHALL be sign-extended to the output widths and added to the real and imaginary accumulators; the counter increments by 1.
REQ-020 On acceptance with counter = length-1, the block SHALL load i/q with the accumulator plus that sample, clear the accumulators and counter, and enter HOLD; s_axis_tvalid is 1 on the following cycle (latency 1 clk from the last sample).
REQ-021 In HOLD, i, q and s_axis_tvalid SHALL stay stable until a rising edge with m_axis_tready=1; the block then returns to ACCUM, and s_axis_tready is 1 on the next cycle.
REQ-022 Input gaps (m_axis_tvalid=0) in ACCUM SHALL leave the accumulators and counter unchanged.
REQ-023 Inputs presented while in HOLD SHALL be ignored, with no state change.
REQ-024 The arithmetic SHALL be exact two's complement; the sizing of REQ-005/006 guarantees no overflow for any length samples, and no saturation or truncation is applied.
REQ-025 i and q SHALL change only when entering HOLD.

Reset
REQ-026 On reset=1 at a rising edge: state=ACCUM, counter=0, accumulators=0, i=0, q=0, s_axis_tvalid=0, s_axis_tready=1 on the next cycle.
REQ-027 Reset SHALL override any simultaneous handshake, discard a partial frame, and drop a held, unconsumed sum.

Structure
REQ-028 The state encoding (ACCUM=1'b0, HOLD=1'b1) SHALL live in the shared caf_pkg package alongside other stream-block constants.
REQ-029 The block SHALL be a single module with no sub-modules; the two identical real/imaginary datapaths are written inline.

Verification
REQ-030 length=4, continuous valid, samples (1,2),(3,-4),(5,6),(-7,8) -> one sum i=2, q=12; s_axis_tvalid rises 1 clk after the 4th acceptance.
REQ-031 Same frame with m_axis_tready held at 0 for 10 cycles -> i=2, q=12 and s_axis_tvalid stay constant, s_axis_tready=0 throughout, no samples accepted.
REQ-032 length=4, i_bits=24, four samples (-8388608,8388607) -> i=-33554432, q=33554428, with no wrap.
REQ-033 Valid toggling 1,0,0,1,1,0,1 -> the sum appears only after the 4th accepted sample and equals the sum of the accepted samples only.
REQ-034 reset pulse after 2 of 4 samples, then a new 4-sample frame -> the output equals the new frame's sum only; reset during HOLD -> s_axis_tvalid=0 next cycle, i=q=0.
REQ-035 Back-to-back frames with m_axis_tready=1 -> exactly one HOLD cycle per frame and correct consecutive sums.
